sram_stream_ctrl: RTL and testbench

SRAM_STREAM_CTRL -- requirements
Module: sram_stream_ctrl

---
 rtl/sram_stream_ctrl_pkg.sv | 16 +
 rtl/sram_stream_fifo2.sv | 51 +++++
 rtl/sram_stream_ctrl.sv | 127 ++++++++++++
 tb/tb_sram_stream_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_stream_ctrl_pkg.sv
// rtl/sram_stream_ctrl_pkg.sv - shared constants and FSM state type for the SRAM stream controller
package sram_stream_ctrl_pkg;

  localparam int WORDSIZE_DEFAULT    = 80;
  localparam int ADDRESSSIZE_DEFAULT = 15;
  localparam int RA_WIDTH            = 11;
  localparam int CA_WIDTH            = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/sram_stream_fifo2.sv
// rtl/sram_stream_fifo2.sv - two-entry output FIFO; slot0 is always the head
module sram_stream_fifo2 #(
  parameter int WIDTH = 80
) (
  input  logic             iClk,
  input  logic             iReset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] slot0;
  logic [WIDTH-1:0] slot1;

  always_ff @(posedge iClk) begin
    if (!iReset) begin
      slot0 <= '0;
      slot1 <= '0;
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) slot0 <= push_data;
          else               slot1 <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          // occupancy is unchanged; the new word lands behind whatever remains
          if (count == 2'd2) begin
            slot0 <= slot1;
            slot1 <= push_data;
          end else begin
            slot0 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_data  = slot0;
  assign head_valid = (count != 2'd0);

endmodule

// File: rtl/sram_stream_ctrl.sv
// rtl/sram_stream_ctrl.sv - writes N streamed words into a synchronous SRAM, then streams them back out
module sram_stream_ctrl
  import sram_stream_ctrl_pkg::*;
#(
  parameter int WORDSIZE    = WORDSIZE_DEFAULT,
  parameter int ADDRESSSIZE = ADDRESSSIZE_DEFAULT
) (
  input  logic                   iClk,
  input  logic                   iReset,
  input  logic                   iStart,
  input  logic [ADDRESSSIZE-1:0] iLast,
  input  logic                   iWrValid,
  input  logic [WORDSIZE-1:0]    iWrData,
  output logic                   oWrReady,
  output logic                   oRdValid,
  output logic [WORDSIZE-1:0]    oRdData,
  input  logic                   iRdReady,
  output logic                   oBusy,
  output logic                   oDone,
  output logic                   oNCE,
  output logic                   oNWRT,
  output logic [RA_WIDTH-1:0]    oRA,
  output logic [CA_WIDTH-1:0]    oCA,
  output logic [WORDSIZE-1:0]    oDIN,
  input  logic [WORDSIZE-1:0]    iDO
);

  state_t                 state;
  state_t                 state_next;
  logic [ADDRESSSIZE:0]   cnt;
  logic [ADDRESSSIZE-1:0] rd_cnt;
  logic [ADDRESSSIZE-1:0] last_q;
  logic                   inflight;

  logic                   wr_fire;
  logic                   rd_issue;
  logic                   rd_pop;
  logic                   last_write;
  logic                   last_pop;
  logic [2:0]             occ_after_pop;
  logic                   head_valid;
  logic [WORDSIZE-1:0]    head_data;
  logic [1:0]             fifo_count;

  // Accesses are gated by reset so an aborted pass never touches the SRAM.
  assign wr_fire       = iReset && (state == ST_WRITE) && iWrValid;
  assign rd_pop        = head_valid && iRdReady;
  // Credit this cycle's pop so a drained slot can be refilled back-to-back.
  assign occ_after_pop = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, rd_pop};
  assign rd_issue      = iReset && (state == ST_READ) && (cnt <= {1'b0, last_q})
                         && (occ_after_pop < 3'd2);
  assign last_write    = wr_fire && (cnt[ADDRESSSIZE-1:0] == last_q);
  assign last_pop      = (state == ST_READ) && rd_pop && (rd_cnt == last_q);

  always_ff @(posedge iClk) begin
    if (!iReset) state <= ST_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (iStart)     state_next = ST_WRITE;
      ST_WRITE: if (last_write) state_next = ST_READ;
      ST_READ:  if (last_pop)   state_next = ST_DONE;
      ST_DONE:                  state_next = ST_IDLE;
      default:                  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    oWrReady = (state == ST_WRITE);
    oBusy    = (state != ST_IDLE);
    oDone    = (state == ST_DONE) && iReset;
    oNCE     = !(wr_fire || rd_issue);
    oNWRT    = !wr_fire;
    oDIN     = wr_fire ? iWrData : '0;
    oRA      = cnt[CA_WIDTH +: RA_WIDTH];
    oCA      = cnt[CA_WIDTH-1:0];
    oRdValid = head_valid;
    oRdData  = head_data;
  end

  always_ff @(posedge iClk) begin
    if (!iReset) begin
      cnt      <= '0;
      rd_cnt   <= '0;
      last_q   <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= rd_issue;
      case (state)
        ST_IDLE: begin
          if (iStart) begin
            last_q <= iLast;
            cnt    <= '0;
            rd_cnt <= '0;
          end
        end
        ST_WRITE: begin
          if (wr_fire) cnt <= last_write ? '0 : cnt + 1'b1;
        end
        ST_READ: begin
          if (rd_issue) cnt    <= cnt + 1'b1;
          if (rd_pop)   rd_cnt <= rd_cnt + 1'b1;
        end
        default: begin
          cnt    <= '0;
          rd_cnt <= '0;
        end
      endcase
    end
  end

  // The SRAM registers Q, so the word for a read issued last cycle is on iDO now.
  sram_stream_fifo2 #(.WIDTH(WORDSIZE)) u_fifo (
    .iClk       (iClk),
    .iReset     (iReset),
    .push       (inflight),
    .push_data  (iDO),
    .pop        (rd_pop),
    .head_data  (head_data),
    .head_valid (head_valid),
    .count      (fifo_count)
  );

endmodule

// File: tb/tb_sram_stream_ctrl.sv
// tb/tb_sram_stream_ctrl.sv - self-checking bench for sram_stream_ctrl with a behavioural 32768x80 SRAM
module tb_sram_stream_ctrl;

  localparam int W  = 80;
  localparam int AW = 15;

  logic          iClk = 1'b0;
  logic          iReset;
  logic          iStart;
  logic [AW-1:0] iLast;
  logic          iWrValid;
  logic [W-1:0]  iWrData;
  logic          oWrReady;
  logic          oRdValid;
  logic [W-1:0]  oRdData;
  logic          iRdReady;
  logic          oBusy;
  logic          oDone;
  logic          oNCE;
  logic          oNWRT;
  logic [10:0]   oRA;
  logic [3:0]    oCA;
  logic [W-1:0]  oDIN;
  logic [W-1:0]  iDO;

  always #5 iClk = ~iClk;

  sram_stream_ctrl #(.WORDSIZE(W), .ADDRESSSIZE(AW)) dut (
    .iClk(iClk), .iReset(iReset), .iStart(iStart), .iLast(iLast),
    .iWrValid(iWrValid), .iWrData(iWrData), .oWrReady(oWrReady),
    .oRdValid(oRdValid), .oRdData(oRdData), .iRdReady(iRdReady),
    .oBusy(oBusy), .oDone(oDone), .oNCE(oNCE), .oNWRT(oNWRT),
    .oRA(oRA), .oCA(oCA), .oDIN(oDIN), .iDO(iDO)
  );

  logic [W-1:0] mem [0:32767];
  always @(posedge iClk) begin
    if (!oNCE) begin
      if (!oNWRT) mem[{oRA, oCA}] <= oDIN;
      else        iDO <= mem[{oRA, oCA}];
    end
  end

  int checks = 0;
  int errors = 0;
  logic [W-1:0] wdata [0:32767];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] r;
    r[31:0]  = $urandom();
    r[63:32] = $urandom();
    r[79:64] = 16'($urandom());
    return r;
  endfunction

  typedef struct {
    logic [AW-1:0] last;
    int            wmode;
    int            rmode;
    bit            timing;
    logic [AW-1:0] exp_final;
  } vec_t;

  task automatic run_pass(input vec_t v);
    int n;
    int wr_idx, hs_err, wr_err, rd_iss, rd_addr_err, acc, data_err;
    int done_cnt, max_out, stab_err, last_wr_cyc, first_acc_cyc, last_acc_cyc, done_cyc;
    bit finished, prev_stall, sram_wr, sram_rd;
    logic [W-1:0]  prev_data;
    logic [AW-1:0] last_wr_addr, last_rd_addr;
    string tag;
    n = int'(v.last) + 1;
    tag = $sformatf("n%0d_w%0d_r%0d", n, v.wmode, v.rmode);
    for (int i = 0; i < n; i++) wdata[i] = rand_word();
    wr_idx = 0; hs_err = 0; wr_err = 0; rd_iss = 0; rd_addr_err = 0; acc = 0; data_err = 0;
    done_cnt = 0; max_out = 0; stab_err = 0; last_wr_cyc = -1; first_acc_cyc = -1;
    last_acc_cyc = -1; done_cyc = -1; finished = 0; prev_stall = 0; prev_data = '0;
    last_wr_addr = '0; last_rd_addr = '0;
    for (int cyc = 0; cyc < 3 * n + 64; cyc++) begin
      @(posedge iClk); #1;
      iStart = (cyc == 0) || (v.rmode == 2 && done_cnt == 0 && $urandom_range(0, 7) == 0);
      iLast  = (cyc == 0) ? v.last : AW'($urandom());
      if (wr_idx < n) begin
        iWrValid = (v.wmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        iWrData  = wdata[wr_idx];
      end else begin
        iWrValid = (v.wmode != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        iWrData  = rand_word();
      end
      case (v.rmode)
        0:       iRdReady = 1'b1;
        1:       iRdReady = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: iRdReady = 1'($urandom_range(0, 1));
      endcase
      @(negedge iClk);
      if (prev_stall && (!oRdValid || oRdData !== prev_data)) stab_err++;
      prev_stall = oRdValid && !iRdReady;
      prev_data  = oRdData;
      sram_wr = !oNCE && !oNWRT;
      sram_rd = !oNCE && oNWRT;
      if ((iWrValid && oWrReady) != sram_wr) hs_err++;
      if (sram_wr) begin
        if (wr_idx >= n || {oRA, oCA} != wr_idx[AW-1:0] || oDIN !== wdata[wr_idx]) wr_err++;
        last_wr_addr = {oRA, oCA};
        last_wr_cyc  = cyc;
        wr_idx++;
      end
      if (sram_rd) begin
        if ({oRA, oCA} != rd_iss[AW-1:0]) rd_addr_err++;
        last_rd_addr = {oRA, oCA};
        rd_iss++;
      end
      if (oRdValid && iRdReady) begin
        if (acc >= n || oRdData !== wdata[acc]) data_err++;
        if (first_acc_cyc < 0) first_acc_cyc = cyc;
        last_acc_cyc = cyc;
        acc++;
      end
      if (rd_iss - acc > max_out) max_out = rd_iss - acc;
      if (oDone) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (done_cnt > 0 && !oBusy) begin
        finished = 1;
        break;
      end
    end
    iStart = 1'b0;
    chk({tag, "_finished_in_budget"}, finished, 1);
    chk({tag, "_sram_writes"}, wr_idx, n);
    chk({tag, "_write_addr_data_errs"}, wr_err, 0);
    chk({tag, "_handshake_vs_sram_errs"}, hs_err, 0);
    chk({tag, "_sram_reads"}, rd_iss, n);
    chk({tag, "_read_addr_errs"}, rd_addr_err, 0);
    chk({tag, "_words_accepted"}, acc, n);
    chk({tag, "_read_data_errs"}, data_err, 0);
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_outstanding_le2"}, max_out <= 2, 1);
    chk({tag, "_stall_stability_errs"}, stab_err, 0);
    chk({tag, "_final_wr_ra"}, last_wr_addr[14:4], v.exp_final[14:4]);
    chk({tag, "_final_wr_ca"}, last_wr_addr[3:0], v.exp_final[3:0]);
    chk({tag, "_final_rd_addr"}, last_rd_addr, v.exp_final);
    if (v.timing) begin
      chk({tag, "_last_write_cycle"}, last_wr_cyc, n);
      chk({tag, "_first_word_latency"}, first_acc_cyc - last_wr_cyc, 3);
      chk({tag, "_back_to_back_reads"}, last_acc_cyc - first_acc_cyc, n - 1);
      chk({tag, "_done_after_last_read"}, done_cyc - last_acc_cyc, 1);
    end
  endtask

  initial begin
    vec_t vecs [6];
    int   issues;
    int   done_seen;
    int   nce_low;
    vecs[0] = '{15'd3,     0, 0, 1'b1, 15'd3};
    vecs[1] = '{15'd7,     0, 1, 1'b0, 15'd7};
    vecs[2] = '{15'd0,     0, 0, 1'b1, 15'd0};
    vecs[3] = '{15'd5,     1, 2, 1'b0, 15'd5};
    vecs[4] = '{15'd31,    1, 2, 1'b0, 15'd31};
    vecs[5] = '{15'd32767, 0, 0, 1'b1, 15'h7FFF};

    iReset = 1'b0; iStart = 1'b0; iLast = '0; iWrValid = 1'b1;
    iWrData = rand_word(); iRdReady = 1'b1;
    repeat (3) @(posedge iClk);
    @(negedge iClk);
    chk("rst_busy", oBusy, 0);
    chk("rst_nce", oNCE, 1);
    chk("rst_nwrt", oNWRT, 1);
    chk("rst_wrready", oWrReady, 0);
    chk("rst_rdvalid", oRdValid, 0);
    chk("rst_done", oDone, 0);
    chk("rst_ra_ca", {oRA, oCA}, 0);
    chk("rst_din_zero", oDIN == '0, 1);
    chk("rst_rddata_zero", oRdData == '0, 1);
    @(posedge iClk); #1;
    iReset = 1'b1;
    @(negedge iClk);
    chk("idle_wrvalid_ignored_ready", oWrReady, 0);
    chk("idle_wrvalid_ignored_nce", oNCE, 1);
    @(posedge iClk); #1;
    iWrValid = 1'b0;

    for (int i = 0; i < 6; i++) run_pass(vecs[i]);

    // abort in READ with two reads outstanding and the consumer stalled
    @(posedge iClk); #1;
    iStart = 1'b1; iLast = 15'd7; iWrValid = 1'b0; iRdReady = 1'b0;
    @(negedge iClk);
    issues = 0;
    for (int c = 0; c < 40 && issues < 2; c++) begin
      @(posedge iClk); #1;
      iStart = 1'b0; iWrValid = 1'b1; iWrData = rand_word();
      @(negedge iClk);
      if (!oNCE && oNWRT) issues++;
    end
    chk("abort_two_reads_issued", issues, 2);
    @(posedge iClk); #1;
    iReset = 1'b0;
    @(negedge iClk);
    chk("abort_no_access_during_reset", oNCE, 1);
    @(posedge iClk); #1;
    iReset = 1'b1; iWrValid = 1'b0;
    @(negedge iClk);
    chk("abort_idle_busy", oBusy, 0);
    chk("abort_rdvalid", oRdValid, 0);
    chk("abort_nce", oNCE, 1);
    done_seen = 0; nce_low = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge iClk); #1;
      iRdReady = 1'b1;
      @(negedge iClk);
      if (oDone) done_seen++;
      if (!oNCE) nce_low++;
    end
    chk("abort_no_done", done_seen, 0);
    chk("abort_no_sram_access", nce_low, 0);
    run_pass('{15'd4, 0, 0, 1'b1, 15'd4});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
